// File: rtl/pipelined_decode_stage.sv
// -----------------------------------------------------------------------------
// pipelined_decode_stage
//
// Single-entry decode stage: decodes a 3-bit opcode into datapath controls,
// reads two operands from an internal register file (with write-through
// bypass), extends the immediate, and registers everything behind a
// valid/ready handshake. A load in the output register whose destination is
// a source of the incoming instruction causes a one-cycle bubble.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready  upstream handshake, instruction bus
//   flush              synchronous kill of the output register and the input
//   wr_en/addr/data    register-file writeback port
//   out_valid/ready    downstream handshake
//   out_*              registered decode results
//   bubble_cnt         saturating count of inserted load-use bubbles
// -----------------------------------------------------------------------------
module pipelined_decode_stage #(
    parameter int  DATA_W     = 16,
    parameter int  REG_CNT    = 8,
    parameter int  INSTR_W    = 16,
    parameter int  IMM_W      = 8,
    parameter int  IMM_SIGNED = 1,
    localparam int REG_AW     = $clog2(REG_CNT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [REG_AW-1:0]  wr_addr,
    input  logic [DATA_W-1:0]  wr_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_mem_read,
    output logic               out_mem_write,
    output logic               out_wb,
    output logic               out_dest_sel,
    output logic               out_use_imm,
    output logic [1:0]         out_alu_op,
    output logic [REG_AW-1:0]  out_rd,
    output logic [DATA_W-1:0]  out_rs1_data,
    output logic [DATA_W-1:0]  out_rs2_data,
    output logic [DATA_W-1:0]  out_imm,
    output logic [15:0]        bubble_cnt
);

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_LDM = 3'b101,
        OP_LD  = 3'b110,
        OP_ST  = 3'b111
    } opcode_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       wb;
        logic       dest_sel;
        logic       mem_read;
        logic       mem_write;
        logic       use_imm;
        logic       reads_rs1;
        logic       reads_rs2;
    } ctrl_t;

    // Contents of the output register; an all-zero value is an empty slot.
    typedef struct packed {
        logic              valid;
        logic [1:0]        alu_op;
        logic              wb;
        logic              dest_sel;
        logic              mem_read;
        logic              mem_write;
        logic              use_imm;
        logic [REG_AW-1:0] rd;
        logic [DATA_W-1:0] rs1_data;
        logic [DATA_W-1:0] rs2_data;
        logic [DATA_W-1:0] imm;
    } stage_t;

    // ------------------------------------------------------------------
    // Instruction fields. rs1 and rd share one field.
    // ------------------------------------------------------------------
    opcode_t           opcode;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [IMM_W-1:0]  imm_raw;
    logic [DATA_W-1:0] imm_ext;

    assign opcode  = opcode_t'(instruction[INSTR_W-1 -: 3]);
    assign rs1     = instruction[INSTR_W-4 -: REG_AW];
    assign rs2     = instruction[INSTR_W-4-REG_AW -: REG_AW];
    assign imm_raw = instruction[IMM_W-1:0];

    generate
        if (IMM_W < DATA_W) begin : g_imm_ext
            logic fill_bit;
            assign fill_bit = (IMM_SIGNED != 0) ? imm_raw[IMM_W-1] : 1'b0;
            assign imm_ext  = {{(DATA_W-IMM_W){fill_bit}}, imm_raw};
        end else begin : g_imm_full
            assign imm_ext = imm_raw;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    ctrl_t ctrl;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        ctrl = '0;
        unique case (opcode)
            OP_NOP: ctrl = '0;
            OP_ADD: begin
                ctrl.alu_op    = 2'b00;
                ctrl.wb        = 1'b1;
                ctrl.dest_sel  = 1'b1;
                ctrl.reads_rs1 = 1'b1;
                ctrl.reads_rs2 = 1'b1;
            end
            OP_SUB: begin
                ctrl.alu_op    = 2'b01;
                ctrl.wb        = 1'b1;
                ctrl.dest_sel  = 1'b1;
                ctrl.reads_rs1 = 1'b1;
                ctrl.reads_rs2 = 1'b1;
            end
            OP_AND: begin
                ctrl.alu_op    = 2'b10;
                ctrl.wb        = 1'b1;
                ctrl.dest_sel  = 1'b1;
                ctrl.reads_rs1 = 1'b1;
                ctrl.reads_rs2 = 1'b1;
            end
            OP_OR: begin
                ctrl.alu_op    = 2'b11;
                ctrl.wb        = 1'b1;
                ctrl.dest_sel  = 1'b1;
                ctrl.reads_rs1 = 1'b1;
                ctrl.reads_rs2 = 1'b1;
            end
            OP_LDM: begin
                ctrl.wb        = 1'b1;
                ctrl.dest_sel  = 1'b1;
                ctrl.use_imm   = 1'b1;
            end
            OP_LD: begin
                ctrl.wb        = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.reads_rs1 = 1'b1;
            end
            OP_ST: begin
                ctrl.mem_write = 1'b1;
                ctrl.reads_rs1 = 1'b1;
                ctrl.reads_rs2 = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Register file: two combinational read ports, one write port.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] regs [REG_CNT];

    // NOTE: the register file is cleared by reset because its contents are
    // architecturally visible as zero after reset; this makes it flops, not
    // a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            regs[wr_addr] <= wr_data;
        end
    end

    // A write in the same cycle is forwarded so a dependent instruction sees
    // the new value without waiting for the edge.
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;

    assign rs1_data = (wr_en && (wr_addr == rs1)) ? wr_data : regs[rs1];
    assign rs2_data = (wr_en && (wr_addr == rs2)) ? wr_data : regs[rs2];

    // ------------------------------------------------------------------
    // Handshake and load-use hazard
    // ------------------------------------------------------------------
    stage_t stage_q;
    stage_t stage_d;
    logic   adv;
    logic   hazard;

    assign adv    = !stage_q.valid || out_ready;
    assign hazard = in_valid && stage_q.valid && stage_q.mem_read &&
                    ((ctrl.reads_rs1 && (stage_q.rd == rs1)) ||
                     (ctrl.reads_rs2 && (stage_q.rd == rs2)));

    assign in_ready = adv && !hazard && !flush;

    // Flush wins over everything; a bubble, an idle cycle and a flush all
    // leave a fully cleared slot so stale controls can never leak out.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (adv) begin
            if (hazard || !in_valid) begin
                stage_d = '0;
            end else begin
                stage_d.valid     = 1'b1;
                stage_d.alu_op    = ctrl.alu_op;
                stage_d.wb        = ctrl.wb;
                stage_d.dest_sel  = ctrl.dest_sel;
                stage_d.mem_read  = ctrl.mem_read;
                stage_d.mem_write = ctrl.mem_write;
                stage_d.use_imm   = ctrl.use_imm;
                stage_d.rd        = rs1;
                stage_d.rs1_data  = rs1_data;
                stage_d.rs2_data  = rs2_data;
                stage_d.imm       = imm_ext;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Bubbles are counted only when one is actually inserted (not on flush).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bubble_cnt <= '0;
        end else if (!flush && adv && hazard && (bubble_cnt != 16'hFFFF)) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end

    assign out_valid     = stage_q.valid;
    assign out_alu_op    = stage_q.alu_op;
    assign out_wb        = stage_q.wb;
    assign out_dest_sel  = stage_q.dest_sel;
    assign out_mem_read  = stage_q.mem_read;
    assign out_mem_write = stage_q.mem_write;
    assign out_use_imm   = stage_q.use_imm;
    assign out_rd        = stage_q.rd;
    assign out_rs1_data  = stage_q.rs1_data;
    assign out_rs2_data  = stage_q.rs2_data;
    assign out_imm       = stage_q.imm;

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_pipelined_decode_stage
//
// Directed bench for pipelined_decode_stage. Two instances share all inputs:
// one with a sign-extended immediate, one zero-extended. Inputs change 1 ns
// after a rising edge; outputs are sampled there too, away from the edge.
// -----------------------------------------------------------------------------
module tb_pipelined_decode_stage;

    localparam int DATA_W  = 16;
    localparam int INSTR_W = 16;
    localparam int REG_AW  = 3;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instruction;
    logic               flush;
    logic               wr_en;
    logic [REG_AW-1:0]  wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic               out_valid;
    logic               out_ready;
    logic               out_mem_read;
    logic               out_mem_write;
    logic               out_wb;
    logic               out_dest_sel;
    logic               out_use_imm;
    logic [1:0]         out_alu_op;
    logic [REG_AW-1:0]  out_rd;
    logic [DATA_W-1:0]  out_rs1_data;
    logic [DATA_W-1:0]  out_rs2_data;
    logic [DATA_W-1:0]  out_imm;
    logic [15:0]        bubble_cnt;

    // Zero-extending instance outputs
    logic               in_ready_u;
    logic               out_valid_u;
    logic               out_mem_read_u;
    logic               out_mem_write_u;
    logic               out_wb_u;
    logic               out_dest_sel_u;
    logic               out_use_imm_u;
    logic [1:0]         out_alu_op_u;
    logic [REG_AW-1:0]  out_rd_u;
    logic [DATA_W-1:0]  out_rs1_data_u;
    logic [DATA_W-1:0]  out_rs2_data_u;
    logic [DATA_W-1:0]  out_imm_u;
    logic [15:0]        bubble_cnt_u;

    pipelined_decode_stage #(.IMM_SIGNED(1)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .flush(flush), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_mem_read(out_mem_read),
        .out_mem_write(out_mem_write), .out_wb(out_wb),
        .out_dest_sel(out_dest_sel), .out_use_imm(out_use_imm),
        .out_alu_op(out_alu_op), .out_rd(out_rd),
        .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
        .out_imm(out_imm), .bubble_cnt(bubble_cnt)
    );

    pipelined_decode_stage #(.IMM_SIGNED(0)) dut_u (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_u),
        .instruction(instruction), .flush(flush), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .out_valid(out_valid_u),
        .out_ready(out_ready), .out_mem_read(out_mem_read_u),
        .out_mem_write(out_mem_write_u), .out_wb(out_wb_u),
        .out_dest_sel(out_dest_sel_u), .out_use_imm(out_use_imm_u),
        .out_alu_op(out_alu_op_u), .out_rd(out_rd_u),
        .out_rs1_data(out_rs1_data_u), .out_rs2_data(out_rs2_data_u),
        .out_imm(out_imm_u), .bubble_cnt(bubble_cnt_u)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; sample and drive 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // opcode | rd/rs1 | rs2 | imm (imm bit 7 overlaps rs2 bit 0)
    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs2, input logic [7:0] imm);
        return {op, rd, rs2, 7'b0} | {8'h00, imm};
    endfunction

    localparam logic [2:0] NOP = 3'b000, ADD = 3'b001, SUB = 3'b010,
                           OR_ = 3'b100, LDM = 3'b101, LD  = 3'b110,
                           ST  = 3'b111;

    initial begin
        reset       = 1'b0;
        in_valid    = 1'b0;
        instruction = '0;
        flush       = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        out_ready   = 1'b1;

        // Reset state
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_bubble_cnt", bubble_cnt, 0);
        check("rst_out_wb", out_wb, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Write R3 = 0x00A5
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h00A5;
        step();
        wr_en = 1'b0;

        // ADD rd=R3, rs2=R3
        in_valid = 1'b1; instruction = mk(ADD, 3'd3, 3'd3, 8'h00);
        step();
        check("add_valid", out_valid, 1);
        check("add_alu_op", out_alu_op, 2'b00);
        check("add_rs1", out_rs1_data, 16'h00A5);
        check("add_rs2", out_rs2_data, 16'h00A5);
        check("add_wb", out_wb, 1);
        check("add_dest_sel", out_dest_sel, 1);
        check("add_rd", out_rd, 3);

        // LDM imm = 0x80
        instruction = mk(LDM, 3'd5, 3'd0, 8'h80);
        step();
        check("ldm_imm_signed", out_imm, 16'hFF80);
        check("ldm_imm_unsigned", out_imm_u, 16'h0080);
        check("ldm_use_imm", out_use_imm, 1);
        check("ldm_wb", out_wb, 1);

        // NOP still occupies a slot
        instruction = mk(NOP, 3'd0, 3'd0, 8'h00);
        step();
        check("nop_valid", out_valid, 1);
        check("nop_wb", out_wb, 0);
        check("nop_use_imm", out_use_imm, 0);

        // ST
        instruction = mk(ST, 3'd3, 3'd0, 8'h00);
        step();
        check("st_mem_write", out_mem_write, 1);
        check("st_wb", out_wb, 0);
        check("st_rs1", out_rs1_data, 16'h00A5);

        // Same-cycle bypass: write R2 = 0x1234 while SUB reads R2
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h1234;
        instruction = mk(SUB, 3'd1, 3'd2, 8'h00);
        #1;
        check("bypass_in_ready", in_ready, 1);
        step();
        wr_en = 1'b0;
        check("bypass_rs2", out_rs2_data, 16'h1234);
        check("sub_alu_op", out_alu_op, 2'b01);

        // Load-use: LD rd=R1 then ADD reading R1
        instruction = mk(LD, 3'd1, 3'd0, 8'h00);
        step();
        check("ld_mem_read", out_mem_read, 1);
        check("ld_dest_sel", out_dest_sel, 0);
        instruction = mk(ADD, 3'd1, 3'd2, 8'h00);
        #1;
        check("hazard_in_ready", in_ready, 0);
        step();
        check("bubble_valid", out_valid, 0);
        check("bubble_wb", out_wb, 0);
        check("bubble_mem_read", out_mem_read, 0);
        check("bubble_cnt_1", bubble_cnt, 1);
        check("after_bubble_in_ready", in_ready, 1);
        step();
        check("add_issue_valid", out_valid, 1);
        check("add_issue_rs1", out_rs1_data, 16'h0000);
        check("add_issue_rs2", out_rs2_data, 16'h1234);
        check("bubble_cnt_hold", bubble_cnt, 1);

        // OR rd=R3 rs2=R2, then stall it for 3 cycles
        instruction = mk(OR_, 3'd3, 3'd2, 8'h00);
        step();
        check("or_alu_op", out_alu_op, 2'b11);
        out_ready   = 1'b0;
        instruction = mk(ADD, 3'd4, 3'd4, 8'h00);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_in_ready", in_ready, 0);
            step();
            wr_en = 1'b0;
            check("stall_valid", out_valid, 1);
            check("stall_alu_op", out_alu_op, 2'b11);
            check("stall_rs1_held", out_rs1_data, 16'h00A5);
            check("stall_rs2_held", out_rs2_data, 16'h1234);
        end
        flush = 1'b1;
        #1;
        check("flush_in_ready", in_ready, 0);
        step();
        flush = 1'b0;
        check("flush_valid", out_valid, 0);

        // Asynchronous reset mid-stall
        out_ready   = 1'b1;
        instruction = mk(LD, 3'd1, 3'd0, 8'h00);
        step();
        check("pre_rst_valid", out_valid, 1);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_mem_read", out_mem_read, 0);
        check("async_rst_rs1", out_rs1_data, 0);
        check("async_rst_bubble", bubble_cnt, 0);
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instruction = mk(ADD, 3'd1, 3'd3, 8'h00);
        #1;
        check("rst_no_hazard_in_ready", in_ready, 1);
        step();
        check("rf_cleared_valid", out_valid, 1);
        check("rf_cleared_rs2", out_rs2_data, 16'h0000);
        in_valid = 1'b0;
        step();
        check("idle_valid", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
